forwarding_scoreboard: RTL and testbench
========================================

Name: forwarding_scoreboard

Overview:
- Parametrised successor to the two-port, two-stage forwarding unit.
- Keeps its own shift register of in-flight destination writes (tag, write enable, load flag) instead of taking EX/MEM and MEM/WB selects as inputs.
- Resolves forwarding for NREAD source operands across DEPTH producer stages and raises a load-use stall when the youngest matching producer is not yet ready.
- Sits beside decode; its outputs drive the operand muxes and the hazard/stall logic.

Parameters:
- NREAD, 2, number of source-operand read ports resolved per cycle.
- DEPTH, 3, number of tracked producer slots (slot 1 = youngest, one stage past decode).
- REGW, 5, register-select width.
- LOAD_LAT, 1, number of slots a load occupies before its data becomes forwardable.
- CNTW, 16, width of the stall statistics counter.

Ports:
- CLK  in  1  core clock.
- nRST  in  1  asynchronous active-low reset.
- advance  in  1  pipeline enable; the slot shift register moves only when this is high.
- flush  in  1  inserts a bubble into slot 1 instead of the issuing instruction.
- issue_valid  in  1  decode holds a real instruction.
- issue_wen  in  1  the decoding instruction writes a register.
- issue_wsel  in  REGW  destination register of the decoding instruction.
- issue_is_load  in  1  the decoding instruction is a load.
- rsel  in  NREAD*REGW  source register per port; port i occupies bits [i*REGW +: REGW].
- rsel_used  in  NREAD  source operand i is actually consumed.
- fwd_sel  out  NREAD*FSW  per-port forwarding source; FSW = $clog2(DEPTH+1); 0 = register file, k = slot k.
- stall  out  1  load-use hazard; decode must hold.
- stall_count  out  CNTW  number of cycles with stall && advance.

Behaviour:
- Slot state: valid, wen, wsel, is_load, age, for k = 1..DEPTH.
  - age counts advances since the entry entered slot 1.
  - On reset, all slots are invalid and stall_count = 0.
  - fwd_sel and stall are combinational from state and inputs, so they read 0 during and immediately after reset.
- Match for port i, slot k: valid && wen && wsel == rsel[i] && rsel[i] != 0 && rsel_used[i].
- fwd_sel[i] = lowest k that matches (youngest producer wins); 0 if no slot matches.
- Ready rule:
  - A non-load entry is ready in any slot.
  - A load entry is ready only when its slot index k > LOAD_LAT.
- stall = OR over ports of (the youngest match for that port is not ready). Older ready matches do not mask a younger unready one.
- On CLK rising edge with advance = 1:
  - slot k <= slot k-1 for k = 2..DEPTH; slot DEPTH is discarded.
  - Slot 1 receives the issuing instruction when issue_valid && !stall && !flush; otherwise it receives a bubble (valid = 0).
  - If stall = 1, stall_count increments, saturating at all-ones.
- advance = 0: all slots and the counter hold. stall and fwd_sel continue to track the current inputs.
- flush together with stall: a bubble is inserted and stall_count still increments.
- issue_wen = 0 or issue_wsel = 0: the entry is inserted but never matches.
- Reset asserted mid-operation: all slots clear asynchronously; no forwarding or stall in the following cycle.
- Compatibility: with NREAD = 2, DEPTH = 2, LOAD_LAT = 1, the block is behaviourally equivalent to the previous unit plus its external load-use detect.

Decomposition:
- Shared pipeline-types package:
  - fwd_slot_t.
  - Constant FWD_REGFILE = 0.
  - Packed struct scoreboard_entry_t {valid, wen, is_load, wsel}.
  - Existing Forward_t retained; a conversion function maps slot 1 and slot 2 onto it.
- Sub-module fwd_port_match: one instance per read port.
  - Inputs: the slot array and one rsel/rsel_used pair.
  - Outputs: the priority-encoded slot index and that port's stall term.
- Top level: slot shift register, issue/bubble mux, stall OR, saturating counter.

Test Plan:
- Reset, then issue add writing r3, advance; next cycle rsel0 = 3 with used -> fwd_sel0 = 1, stall = 0. Advance again -> fwd_sel0 = 2.
- lw r4, advance; next cycle rsel1 = 4 -> stall = 1, fwd_sel1 = 1. Advance -> slot 1 gets a bubble, stall_count = 1. Following cycle -> stall = 0, fwd_sel1 = 2.
- Two producers of r5 in slots 1 and 3 -> fwd_sel0 = 1. With rsel0 = 0 or rsel_used0 = 0 -> fwd_sel0 = 0.
- Hold advance low for 4 cycles with stall high -> slots and stall_count unchanged. Flush with advance on a valid issue -> slot 1 invalid.
- Preload stall_count to all-ones by forcing stalls (CNTW = 4 build: 16 stall cycles) -> count stays 15.
- Pulse nRST low asynchronously between edges with 3 valid slots -> fwd_sel = 0, stall = 0, stall_count = 0 before the next edge.

Source files
------------

// File: rtl/forwarding_scoreboard_pkg.sv
// Shared pipeline types for the forwarding scoreboard and its per-port matcher.
// Combinational helpers only; no state.
// No flow control.
package forwarding_scoreboard_pkg;

  localparam int PKG_DEPTH = 3;
  localparam int PKG_REGW  = 5;
  localparam int PKG_FSW   = $clog2(PKG_DEPTH + 1);

  // Forwarding source index: 0 = register file, k = producer slot k.
  typedef logic [PKG_FSW-1:0] fwd_slot_t;

  localparam fwd_slot_t FWD_REGFILE = '0;

  // One tracked in-flight destination write.
  typedef struct packed {
    logic                valid;
    logic                wen;
    logic                is_load;
    logic [PKG_REGW-1:0] wsel;
  } scoreboard_entry_t;

  // Mux select encoding used by the older two-stage forwarding unit.
  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } Forward_t;

  // Slot 1 sits where EX/MEM used to be, slot 2 where MEM/WB used to be.
  function automatic Forward_t to_forward(input fwd_slot_t s);
    case (s)
      fwd_slot_t'(1): to_forward = FWD_EXMEM;
      fwd_slot_t'(2): to_forward = FWD_MEMWB;
      default:        to_forward = FWD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/forwarding_scoreboard_port_match.sv
// Per-read-port priority match of one source register against all producer slots.
// Purely combinational (0 cycles).
// No flow control; emits this port's load-use stall term.
module fwd_port_match
  import forwarding_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int REGW     = 5,
  parameter int LOAD_LAT = 1,
  parameter int FSW      = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0]      slot_valid_i,
  input  logic [DEPTH-1:0]      slot_wen_i,
  input  logic [DEPTH-1:0]      slot_load_i,
  input  logic [DEPTH*REGW-1:0] slot_wsel_i,
  input  logic [REGW-1:0]       rsel_i,
  input  logic                  rsel_used_i,
  output logic [FSW-1:0]        fwd_sel_o,
  output logic                  stall_o
);

  // Scan oldest to youngest so the youngest match overwrites; its readiness alone decides the stall.
  always_comb begin
    fwd_sel_o = FSW'(FWD_REGFILE);
    stall_o   = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (slot_valid_i[k-1] && slot_wen_i[k-1] &&
          (slot_wsel_i[(k-1)*REGW +: REGW] == rsel_i) &&
          (rsel_i != '0) && rsel_used_i) begin
        fwd_sel_o = FSW'(k);
        stall_o   = slot_load_i[k-1] && (k <= LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Tracks in-flight register writes and resolves operand forwarding / load-use stalls.
// fwd_sel and stall are combinational; slot state moves one stage per advance.
// Holds everything while advance is low; stall inserts a bubble into slot 1.
module forwarding_scoreboard
  import forwarding_scoreboard_pkg::*;
#(
  parameter int NREAD    = 2,
  parameter int DEPTH    = 3,
  parameter int REGW     = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNTW     = 16,
  localparam int FSW     = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  advance,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic                  issue_wen,
  input  logic [REGW-1:0]       issue_wsel,
  input  logic                  issue_is_load,
  input  logic [NREAD*REGW-1:0] rsel,
  input  logic [NREAD-1:0]      rsel_used,
  output logic [NREAD*FSW-1:0]  fwd_sel,
  output logic                  stall,
  output logic [CNTW-1:0]       stall_count
);

  // Same layout as scoreboard_entry_t, but sized by this instance's REGW.
  // An entry's age is implied by its slot index (slot k has seen k-1 advances).
  typedef struct packed {
    logic            valid;
    logic            wen;
    logic            is_load;
    logic [REGW-1:0] wsel;
  } entry_t;

  entry_t [DEPTH-1:0] slot_q, slot_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;

  logic [DEPTH-1:0]      slot_valid, slot_wen, slot_load;
  logic [DEPTH*REGW-1:0] slot_wsel;
  logic [NREAD-1:0]      port_stall;
  logic                  issue_take;

  // Flatten slot state for the per-port matchers.
  always_comb begin
    slot_valid = '0;
    slot_wen   = '0;
    slot_load  = '0;
    slot_wsel  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot_valid[k]               = slot_q[k].valid;
      slot_wen[k]                 = slot_q[k].wen;
      slot_load[k]                = slot_q[k].is_load;
      slot_wsel[k*REGW +: REGW]   = slot_q[k].wsel;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    fwd_port_match #(
      .DEPTH    (DEPTH),
      .REGW     (REGW),
      .LOAD_LAT (LOAD_LAT),
      .FSW      (FSW)
    ) u_match (
      .slot_valid_i (slot_valid),
      .slot_wen_i   (slot_wen),
      .slot_load_i  (slot_load),
      .slot_wsel_i  (slot_wsel),
      .rsel_i       (rsel[p*REGW +: REGW]),
      .rsel_used_i  (rsel_used[p]),
      .fwd_sel_o    (fwd_sel[p*FSW +: FSW]),
      .stall_o      (port_stall[p])
    );
  end

  assign stall       = |port_stall;
  assign issue_take  = issue_valid && !stall && !flush;
  assign stall_count = cnt_q;

  // Next state: shift on advance, slot 1 takes the issue or a bubble; saturating stall counter.
  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    if (advance) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        slot_d[k] = slot_q[k-1];
      end
      slot_d[0] = '0;
      if (issue_take) begin
        slot_d[0].valid   = 1'b1;
        slot_d[0].wen     = issue_wen;
        slot_d[0].is_load = issue_is_load;
        slot_d[0].wsel    = issue_wsel;
      end
      if (stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset empties every slot and clears the counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      slot_q <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard (DEPTH=3, LOAD_LAT=1, CNTW=4 build).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
// Expected values are hand-derived from the slot contents each step creates.
module tb_forwarding_scoreboard;

  localparam int NREAD = 2;
  localparam int DEPTH = 3;
  localparam int REGW  = 5;
  localparam int FSW   = 2;
  localparam int CNTW  = 4;

  logic                  CLK;
  logic                  nRST;
  logic                  advance;
  logic                  flush;
  logic                  issue_valid;
  logic                  issue_wen;
  logic [REGW-1:0]       issue_wsel;
  logic                  issue_is_load;
  logic [NREAD*REGW-1:0] rsel;
  logic [NREAD-1:0]      rsel_used;
  logic [NREAD*FSW-1:0]  fwd_sel;
  logic                  stall;
  logic [CNTW-1:0]       stall_count;

  int tests = 0;
  int fails = 0;

  forwarding_scoreboard #(
    .NREAD    (NREAD),
    .DEPTH    (DEPTH),
    .REGW     (REGW),
    .LOAD_LAT (1),
    .CNTW     (CNTW)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .advance       (advance),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_wen     (issue_wen),
    .issue_wsel    (issue_wsel),
    .issue_is_load (issue_is_load),
    .rsel          (rsel),
    .rsel_used     (rsel_used),
    .fwd_sel       (fwd_sel),
    .stall         (stall),
    .stall_count   (stall_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic v, input logic wen, input int wsel, input logic ld);
    issue_valid   = v;
    issue_wen     = wen;
    issue_wsel    = REGW'(wsel);
    issue_is_load = ld;
  endtask

  task automatic rd(input int port, input int r, input logic used);
    rsel[port*REGW +: REGW] = REGW'(r);
    rsel_used[port]         = used;
  endtask

  function automatic int fs(input int port);
    return int'(fwd_sel[port*FSW +: FSW]);
  endfunction

  initial begin
    nRST = 1'b0;
    advance = 1'b0;
    flush = 1'b0;
    issue(1'b0, 1'b0, 0, 1'b0);
    rsel = '0;
    rsel_used = '0;
    #2;
    chk("reset_fwd", int'(fwd_sel), 0);
    chk("reset_stall", int'(stall), 0);
    chk("reset_count", int'(stall_count), 0);
    #10 nRST = 1'b1;

    // add r3 into slot 1
    advance = 1'b1;
    issue(1'b1, 1'b1, 3, 1'b0);
    tick();
    issue(1'b0, 1'b0, 0, 1'b0);
    advance = 1'b0;
    rd(0, 3, 1'b1);
    #1;
    chk("add_fwd_slot1", fs(0), 1);
    chk("add_no_stall", int'(stall), 0);
    advance = 1'b1;
    tick();
    chk("add_fwd_slot2", fs(0), 2);
    rd(0, 0, 1'b0);
    repeat (3) tick();

    // lw r4 followed by a consumer on port 1
    issue(1'b1, 1'b1, 4, 1'b1);
    tick();
    issue(1'b1, 1'b1, 6, 1'b0);
    rd(1, 4, 1'b1);
    #1;
    chk("lw_stall", int'(stall), 1);
    chk("lw_fwd_slot1", fs(1), 1);
    tick();
    chk("lw_count", int'(stall_count), 1);
    chk("lw_stall_clears", int'(stall), 0);
    chk("lw_fwd_slot2", fs(1), 2);
    tick();
    chk("lw_fwd_slot3", fs(1), 3);
    issue(1'b0, 1'b0, 0, 1'b0);
    rd(1, 0, 1'b0);
    repeat (3) tick();

    // r5 in slots 1 and 3, an r0 writer in slot 2
    issue(1'b1, 1'b1, 5, 1'b0);
    tick();
    issue(1'b1, 1'b1, 0, 1'b0);
    tick();
    issue(1'b1, 1'b1, 5, 1'b0);
    tick();
    issue(1'b0, 1'b0, 0, 1'b0);
    advance = 1'b0;
    rd(0, 5, 1'b1);
    #1;
    chk("youngest_wins", fs(0), 1);
    rd(0, 5, 1'b0);
    #1;
    chk("unused_no_fwd", fs(0), 0);
    rd(0, 0, 1'b1);
    #1;
    chk("r0_no_fwd", fs(0), 0);
    rd(0, 0, 1'b0);
    advance = 1'b1;
    repeat (3) tick();

    // add r7 older, lw r7 younger: the unready younger load must stall
    issue(1'b1, 1'b1, 7, 1'b0);
    tick();
    issue(1'b1, 1'b1, 7, 1'b1);
    tick();
    advance = 1'b0;
    issue(1'b1, 1'b1, 9, 1'b0);
    rd(0, 7, 1'b1);
    #1;
    chk("no_mask_stall", int'(stall), 1);
    chk("no_mask_fwd", fs(0), 1);
    repeat (4) tick();
    chk("hold_stall", int'(stall), 1);
    chk("hold_fwd", fs(0), 1);
    chk("hold_count", int'(stall_count), 1);

    // flush on a valid issue inserts a bubble
    rd(0, 7, 1'b0);
    flush = 1'b1;
    advance = 1'b1;
    tick();
    flush = 1'b0;
    issue(1'b0, 1'b0, 0, 1'b0);
    advance = 1'b0;
    rd(1, 9, 1'b1);
    rd(0, 7, 1'b1);
    #1;
    chk("flush_bubble", fs(1), 0);
    chk("flush_load_moved", fs(0), 2);
    chk("flush_load_ready", int'(stall), 0);
    chk("flush_count", int'(stall_count), 1);
    rd(0, 0, 1'b0);
    rd(1, 0, 1'b0);
    advance = 1'b1;

    // counter saturation: each iteration adds one counted stall
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 1'b1, 8, 1'b1);
      rd(0, 0, 1'b0);
      tick();
      issue(1'b0, 1'b0, 0, 1'b0);
      rd(0, 8, 1'b1);
      tick();
      if (i == 12) chk("count_pre_sat", int'(stall_count), 14);
    end
    chk("count_saturated", int'(stall_count), 15);
    rd(0, 0, 1'b0);

    // fill three slots, then pulse reset between edges
    issue(1'b1, 1'b1, 10, 1'b0);
    tick();
    issue(1'b1, 1'b1, 11, 1'b0);
    tick();
    issue(1'b1, 1'b1, 12, 1'b1);
    tick();
    issue(1'b0, 1'b0, 0, 1'b0);
    advance = 1'b0;
    rd(0, 12, 1'b1);
    rd(1, 10, 1'b1);
    #1;
    chk("pre_rst_stall", int'(stall), 1);
    chk("pre_rst_fwd1", fs(1), 3);
    #1 nRST = 1'b0;
    #1;
    chk("arst_fwd", int'(fwd_sel), 0);
    chk("arst_stall", int'(stall), 0);
    chk("arst_count", int'(stall_count), 0);
    nRST = 1'b1;
    tick();
    chk("post_rst_fwd", int'(fwd_sel), 0);
    chk("post_rst_stall", int'(stall), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
